// File: rtl/tts_pkg.sv
// Shared types and constants for the truth table scanner.
//   state_e   : scanner FSM states
//   VEC_COUNT : number of two-input vectors per scan
//   IDX_W     : width of the vector index
package tts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned VEC_COUNT = 4;
    localparam int unsigned IDX_W     = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

    typedef logic [VEC_COUNT-1:0] table_t;

endpackage

// File: rtl/tts_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled, then wraps to 0.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable
//   cnt        : current count (registered)
//   last_c     : combinational strobe, high while cnt == DWELL-1
module tts_dwell_cnt #(
    parameter int unsigned DWELL = 10,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_c = (cnt_q == CNT_W'(DWELL - 1));
    assign cnt    = cnt_q;

    // Next count: never exceeds DWELL-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Truth table scanner: steps x/y through 00,01,10,11, holds each vector for
// DWELL cycles, samples z in the last cycle of each dwell, and compares the
// captured 4-bit table against an expected table latched at start.
//   clk, rst_n : clock, async active-low reset
//   start      : scan request (ignored unless idle)
//   expected   : expected z per vector, bit i for {x,y}=i
//   z          : output of the experiment under test
//   x, y       : registered stimulus
//   busy       : scan in progress
//   done       : one-cycle completion pulse
//   table_o    : captured z values, bit i for vector i
//   pass       : captured table matched (held until next accepted start)
//   glitch     : (TTS_GLITCH_CHECK_EN only) z moved outside the settle window
// Optional feature macro: TTS_GLITCH_CHECK_EN.
module truth_table_scanner
    import tts_pkg::*;
#(
    parameter int unsigned DWELL = 10,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [VEC_COUNT-1:0] expected,
    input  logic                 z,
    output logic                 x,
    output logic                 y,
    output logic                 busy,
    output logic                 done,
    output logic [VEC_COUNT-1:0] table_o,
`ifdef TTS_GLITCH_CHECK_EN
    output logic                 glitch,
`endif
    output logic                 pass
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    table_t           exp_q, exp_d;
    table_t           table_q, table_d;
    logic             pass_q, pass_d;
    logic             x_q, x_d;
    logic             y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] cnt;
    logic             last_c;

    tts_dwell_cnt #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != ST_DRIVE),
        .en     (state_q == ST_DRIVE),
        .cnt    (cnt),
        .last_c (last_c)
    );

`ifdef TTS_GLITCH_CHECK_EN
    logic glitch_q, glitch_d;
    logic z_prev_q;
`else
    // The count only feeds the glitch settle window, absent in this build.
    logic unused_cnt;
    assign unused_cnt = ^cnt;
`endif

    // Next-state, sampling and compare.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        exp_d   = exp_q;
        table_d = table_q;
        pass_d  = pass_q;
        x_d     = 1'b0;
        y_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef TTS_GLITCH_CHECK_EN
        glitch_d = glitch_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    table_d = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
`ifdef TTS_GLITCH_CHECK_EN
                    glitch_d = 1'b0;
`endif
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                x_d    = idx_q[1];
                y_d    = idx_q[0];
                busy_d = 1'b1;
`ifdef TTS_GLITCH_CHECK_EN
                // First two cycles of a vector are the settle window.
                if ((cnt >= CNT_W'(2)) && (z != z_prev_q)) begin
                    glitch_d = 1'b1;
                end
`endif
                if (last_c) begin
                    table_d[idx_q] = z;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
`ifdef TTS_GLITCH_CHECK_EN
                pass_d = (table_q == exp_q) && !glitch_q;
`else
                pass_d = (table_q == exp_q);
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            pass_q  <= pass_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef TTS_GLITCH_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= 1'b0;
            z_prev_q <= 1'b0;
        end else begin
            glitch_q <= glitch_d;
            z_prev_q <= z;
        end
    end

    assign glitch = glitch_q;
`endif

    assign x       = x_q;
    assign y       = y_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign table_o = table_q;
    assign pass    = pass_q;

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Hardware counterpart to the two-input stimulus benches: drives x/y through 00, 01, 10, 11 and reads back the DUT output z.
- Holds each vector for DWELL cycles and samples z in the last cycle of each dwell.
- Assembles a 4-bit captured truth table and compares it against an expected table.
- Sits beside any two-input combinational experiment (task2_xx style) for self-checking on the board.

Parameters:
- DWELL, 10, clock cycles each vector is held (legal range >= 2).
- CNT_W, 8, width of the dwell counter (must satisfy 2**CNT_W > DWELL).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a scan; ignored while busy=1.
- expected  in  4  expected z per vector; bit i corresponds to {x,y}=i.
- z  in  1  DUT output; same clock domain, no synchronizer.
- x  out  1  stimulus MSB (idx[1]).
- y  out  1  stimulus LSB (idx[0]).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the scan completes.
- table_o  out  4  captured z values; bit i = z sampled for vector i.
- pass  out  1  table_o == latched expected; valid from done until the next accepted start.

Behaviour:
- Reset (asynchronous): state=IDLE, x=y=0, busy=0, done=0, table_o=0, pass=0, idx=0, cnt=0.
- Reset mid-scan aborts immediately to the same values; no partial result is retained.

State IDLE:
- x=y=0.
- start=1: latch expected, clear table_o and pass, set idx=0 and cnt=0, go to DRIVE.

State DRIVE:
- x=idx[1], y=idx[0], both registered outputs; busy=1.
- Each cycle cnt increments.
- When cnt==DWELL-1: table_o[idx] <= z and cnt <= 0.
  - idx<3: idx increments.
  - idx==3: go to DONE.

State DONE (one cycle):
- done=1, busy=0, x=y=0; pass <= (table_o == expected_q).
- Next state is IDLE.
- start asserted in the DONE cycle is ignored. It is accepted on the next IDLE cycle only if still asserted.

Timing:
- start sampled at edge 0.
- x/y=00 visible after edge 1.
- Vector k is sampled at edge 1+(k+1)*DWELL-1.
- done is high during the cycle after edge 4*DWELL+1.
- Total latency start->done = 4*DWELL+1 cycles.

Hold and width rules:
- table_o and pass hold after DONE until the next accepted start.
- idx is 2 bits and never wraps past 3.
- cnt saturates logically at DWELL-1.

Optional Feature:
- Macro: TTS_GLITCH_CHECK_EN.
- Defined:
  - Adds output port glitch (1 bit, reset 0, cleared on accepted start).
  - In DRIVE, for cnt >= 2, z is compared to its previous-cycle value. Any change sets glitch sticky.
  - The first two cycles of each vector are the settle window.
  - In DONE, pass <= (table_o == expected_q) && !glitch.
- Undefined:
  - No glitch port and no comparison register.
  - pass depends only on the table compare.

Decomposition:
- Package tts_pkg:
  - state enum {ST_IDLE, ST_DRIVE, ST_DONE}.
  - VEC_COUNT = 4.
  - IDX_W = 2.
- One natural sub-module, tts_dwell_cnt: clear/enable inputs, DWELL parameter, outputs cnt and a last-cycle strobe.
- FSM, sampling and compare stay in truth_table_scanner.

Test Plan:
- XOR DUT (z = x^y), DWELL=10, expected=4'b0110, start pulse -> x/y steps 00,01,10,11 every 10 cycles; done at cycle 41; table_o=0110, pass=1.
- AND DUT, expected=4'b0110 -> table_o=1000, pass=0; both hold through 20 idle cycles.
- start re-pulsed at cycles 5 and 25 during a scan -> ignored; exactly one done; done still at cycle 41.
- rst_n low during vector 2 (cycle 25) -> x=y=busy=done=0 and table_o=0 asynchronously. After release, a new start gives a full correct scan.
- start held high through DONE -> second scan accepted on the first IDLE cycle; table_o cleared at acceptance.
- With TTS_GLITCH_CHECK_EN, XOR DUT, z forced inverted for one cycle at cnt=5 of vector 1 -> glitch=1, pass=0 while table_o=0110. Without the macro, the same stimulus gives pass=1.
